wb_writer: RTL and testbench
============================

Name: wb_writer

Overview:
- Writeback-side producer for the 16-entry register file.
- Collects results from the ALU and the load/store unit (LSU) over valid/ready handshakes and buffers them in order in a small FIFO.
- Drives the regfile write port (write enable, index, data) at most once per cycle.
- Exports a pending-write mask so decode can detect hazards against writes not yet committed.

Parameters:
- WORD_WIDTH, 16, data width; must match the regfile.
- IDX_WIDTH, 4, register index width; NUM_REGS = 2**IDX_WIDTH.
- DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_mem_valid  in  1  LSU result valid
- out_mem_ready  out  1  LSU result accepted this cycle
- in_mem_idx  in  IDX_WIDTH  LSU destination register
- in_mem_data  in  WORD_WIDTH  LSU result
- in_alu_valid  in  1  ALU result valid
- out_alu_ready  out  1  ALU result accepted this cycle
- in_alu_idx  in  IDX_WIDTH  ALU destination register
- in_alu_data  in  WORD_WIDTH  ALU result
- in_stall  in  1  hold the write port (debug halt / port borrowed)
- out_write  out  1  regfile write enable
- out_dst_idx  out  IDX_WIDTH  regfile write index
- out_dst  out  WORD_WIDTH  regfile write data
- out_pending  out  NUM_REGS  bit i set = write to r[i] buffered or on port
- in_src1_idx, in_src2_idx  in  IDX_WIDTH  bypass lookup indices (see feature)
- out_byp1_hit, out_byp2_hit  out  1  bypass hit
- out_byp1_data, out_byp2_data  out  WORD_WIDTH  bypass data

Behaviour:
- Reset:
  - Synchronous, active-high; wins over every other event in the same cycle.
  - out_write=0, out_dst_idx=0, out_dst=0, FIFO count=0, pointers=0, out_pending=0.
  - Any in-flight entries are discarded.
- Readies (combinational, from registered count only; not pop-aware):
  - out_mem_ready = (count<DEPTH).
  - out_alu_ready = (count<DEPTH) && !in_mem_valid.
  - LSU has priority; at most one acceptance per cycle.
- Acceptance: valid&&ready at a rising edge. An entry with idx==0 completes the handshake but is dropped; it is never enqueued and never drives out_write.
- Output register: out_write/out_dst_idx/out_dst are registered.
  - Each edge with !in_stall: if FIFO non-empty, head moves to the output register with out_write=1 and is popped; else if an entry is accepted this edge with count==0, it cuts through directly to the output register (latency 1: out_write high in the cycle after the accepting edge); else out_write=0.
  - Each edge with in_stall: out_write<=0, no pop; acceptance continues into the FIFO, cut-through disabled.
- Simultaneous pop and enqueue at count==DEPTH cannot occur, because ready is low. Pop and enqueue in the same edge leave count unchanged.
- Ordering: strictly acceptance order; the regfile sees writes in that order.
- out_pending (combinational): OR over valid FIFO entries plus the output register when out_write=1. Bit 0 is always 0.
- count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro WB_WRITER_BYPASS_EN.
- Defined:
  - out_bypN_hit=1 when in_srcN_idx!=0 and it matches any valid FIFO entry or the output register (out_write=1).
  - out_bypN_data = the youngest match: FIFO tail side first, output register last.
  - Purely combinational.
- Undefined: out_bypN_hit=0 and out_bypN_data=0 constantly; the in_srcN_idx inputs are ignored.

Decomposition:
- Package swt16_pkg: WORD_WIDTH, IDX_WIDTH, NUM_REGS constants; typedef wb_entry_t {idx, data}.
- Sub-module wb_fifo: DEPTH-entry circular buffer of wb_entry_t with push/pop, count, and per-entry valid vector for the pending/bypass scans.

Test Plan:
- Reset, then ALU r3=0x1234 with FIFO empty and no stall -> next cycle out_write=1, idx=3, data=0x1234; out_pending[3]=1 for exactly that cycle.
- Same-cycle LSU r5=0xAAAA and ALU r6=0xBBBB -> mem accepted, alu_ready=0; ALU accepted next cycle; writes r5 then r6 on consecutive cycles.
- in_stall=1 while pushing r1..r4 = 0x0001..0x0004 -> after 4 accepts mem_ready=0, out_pending=0x001E; release stall -> r1..r4 written in order over 4 cycles, then ready=1.
- ALU write to r0 with data 0xFFFF -> handshake completes, out_write stays 0, out_pending unchanged.
- With WB_WRITER_BYPASS_EN, stall, push r7=0x1111 then r7=0x2222, in_src1_idx=7 -> byp1_hit=1, data=0x2222; in_src2_idx=0 -> hit=0.
- Assert reset with 3 entries buffered and stall high -> next cycle out_write=0, out_pending=0, both readies 1; no stale writes afterwards.

Source files
------------

// File: rtl/swt16_pkg.sv
// Shared constants and the writeback entry type
// for the 16-bit, 16-register core slice.
package swt16_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int IDX_WIDTH  = 4;
    localparam int NUM_REGS   = 2 ** IDX_WIDTH;

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  idx;
        logic [WORD_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries.
// Entries are exported oldest-first with a matching valid vector.
module wb_fifo
    import swt16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t [DEPTH-1:0]    ages,
    output logic [DEPTH-1:0]         valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Rotate storage so index 0 is always the head.
    always_comb begin
        ages  = '0;
        valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ages[k]  = mem[rd_ptr + PW'(k)];
            valid[k] = CW'(k) < count;
        end
    end

endmodule

// File: rtl/wb_writer.sv
// Writeback producer: merges LSU/ALU results in order onto the regfile port.
// Define WB_WRITER_BYPASS_EN to enable the combinational bypass lookup.
module wb_writer
    import swt16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_mem_valid,
    output logic                  out_mem_ready,
    input  logic [IDX_WIDTH-1:0]  in_mem_idx,
    input  logic [WORD_WIDTH-1:0] in_mem_data,
    input  logic                  in_alu_valid,
    output logic                  out_alu_ready,
    input  logic [IDX_WIDTH-1:0]  in_alu_idx,
    input  logic [WORD_WIDTH-1:0] in_alu_data,
    input  logic                  in_stall,
    output logic                  out_write,
    output logic [IDX_WIDTH-1:0]  out_dst_idx,
    output logic [WORD_WIDTH-1:0] out_dst,
    output logic [NUM_REGS-1:0]   out_pending,
    input  logic [IDX_WIDTH-1:0]  in_src1_idx,
    input  logic [IDX_WIDTH-1:0]  in_src2_idx,
    output logic                  out_byp1_hit,
    output logic                  out_byp2_hit,
    output logic [WORD_WIDTH-1:0] out_byp1_data,
    output logic [WORD_WIDTH-1:0] out_byp2_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]         count;
    wb_entry_t [DEPTH-1:0] ages;
    logic [DEPTH-1:0]      valid;
    wb_entry_t             acc;
    logic                  take;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  cut;

    assign out_mem_ready = count < CW'(DEPTH);
    assign out_alu_ready = out_mem_ready && !in_mem_valid;

    // LSU wins; r0 results finish the handshake but are dropped here.
    always_comb begin
        acc.idx  = in_mem_valid ? in_mem_idx  : in_alu_idx;
        acc.data = in_mem_valid ? in_mem_data : in_alu_data;
        take     = ((in_mem_valid && out_mem_ready) ||
                    (in_alu_valid && out_alu_ready)) &&
                   (acc.idx != '0);
        empty    = count == '0;
        pop      = !in_stall && !empty;
        push     = take && (in_stall || !empty);
        cut      = take && !in_stall && empty;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (acc),
        .count (count),
        .ages  (ages),
        .valid (valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            out_write   <= 1'b0;
            out_dst_idx <= '0;
            out_dst     <= '0;
        end else if (pop) begin
            out_write   <= 1'b1;
            out_dst_idx <= ages[0].idx;
            out_dst     <= ages[0].data;
        end else if (cut) begin
            out_write   <= 1'b1;
            out_dst_idx <= acc.idx;
            out_dst     <= acc.data;
        end else begin
            out_write   <= 1'b0;
        end
    end

    always_comb begin
        out_pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k]) out_pending[ages[k].idx] = 1'b1;
        end
        if (out_write) out_pending[out_dst_idx] = 1'b1;
        out_pending[0] = 1'b0;
    end

`ifdef WB_WRITER_BYPASS_EN
    // Scan oldest to youngest so the last match is the freshest value.
    function automatic logic [WORD_WIDTH:0] lookup(
        input logic [IDX_WIDTH-1:0] src,
        input wb_entry_t [DEPTH-1:0] e,
        input logic [DEPTH-1:0]     v,
        input logic                 w,
        input logic [IDX_WIDTH-1:0] w_idx,
        input logic [WORD_WIDTH-1:0] w_data
    );
        logic [WORD_WIDTH:0] r;
        r = '0;
        if (src != '0) begin
            if (w && w_idx == src) r = {1'b1, w_data};
            for (int k = 0; k < DEPTH; k++) begin
                if (v[k] && e[k].idx == src) r = {1'b1, e[k].data};
            end
        end
        return r;
    endfunction

    always_comb begin
        {out_byp1_hit, out_byp1_data} =
            lookup(in_src1_idx, ages, valid, out_write, out_dst_idx, out_dst);
        {out_byp2_hit, out_byp2_data} =
            lookup(in_src2_idx, ages, valid, out_write, out_dst_idx, out_dst);
    end
`else
    logic unused_src;
    assign unused_src    = ^{in_src1_idx, in_src2_idx};
    assign out_byp1_hit  = 1'b0;
    assign out_byp2_hit  = 1'b0;
    assign out_byp1_data = '0;
    assign out_byp2_data = '0;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// Randomized bench for wb_writer against a queue-based reference model.
// Honors WB_WRITER_BYPASS_EN for the bypass expectations.
module tb_wb_writer;
    import swt16_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_mem_valid, in_alu_valid, in_stall;
    logic        out_mem_ready, out_alu_ready, out_write;
    logic [3:0]  in_mem_idx, in_alu_idx, in_src1_idx, in_src2_idx, out_dst_idx;
    logic [15:0] in_mem_data, in_alu_data, out_dst;
    logic [15:0] out_pending, out_byp1_data, out_byp2_data;
    logic        out_byp1_hit, out_byp2_hit;

    always #5 clock = ~clock;

    wb_writer #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_mem_valid  (in_mem_valid),
        .out_mem_ready (out_mem_ready),
        .in_mem_idx    (in_mem_idx),
        .in_mem_data   (in_mem_data),
        .in_alu_valid  (in_alu_valid),
        .out_alu_ready (out_alu_ready),
        .in_alu_idx    (in_alu_idx),
        .in_alu_data   (in_alu_data),
        .in_stall      (in_stall),
        .out_write     (out_write),
        .out_dst_idx   (out_dst_idx),
        .out_dst       (out_dst),
        .out_pending   (out_pending),
        .in_src1_idx   (in_src1_idx),
        .in_src2_idx   (in_src2_idx),
        .out_byp1_hit  (out_byp1_hit),
        .out_byp2_hit  (out_byp2_hit),
        .out_byp1_data (out_byp1_data),
        .out_byp2_data (out_byp2_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_w;
    logic [3:0]  m_idx;
    logic [15:0] m_data;
    bit          known = 0;
`ifdef WB_WRITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [15:0] ref_pending();
        logic [15:0] p = '0;
        foreach (q[i]) p[q[i].idx] = 1'b1;
        if (m_w) p[m_idx] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Most recently accepted match wins; the output register is oldest.
    function automatic logic [16:0] ref_byp(input logic [3:0] s);
        logic [16:0] r = '0;
        if (BYP && s != 0) begin
            if (m_w && m_idx == s) r = {1'b1, m_data};
            foreach (q[i]) if (q[i].idx == s) r = {1'b1, q[i].data};
        end
        return r;
    endfunction

    task automatic cycle(input bit rst, input bit mv, input logic [3:0] mi,
                         input logic [15:0] md, input bit av,
                         input logic [3:0] ai, input logic [15:0] ad,
                         input bit st, input logic [3:0] s1,
                         input logic [3:0] s2);
        bit   rdy_m, rdy_a, acc;
        ent_t e;
        @(negedge clock);
        reset = rst;
        in_mem_valid = mv; in_mem_idx = mi; in_mem_data = md;
        in_alu_valid = av; in_alu_idx = ai; in_alu_data = ad;
        in_stall = st; in_src1_idx = s1; in_src2_idx = s2;
        #1;
        rdy_m = q.size() < DEPTH;
        rdy_a = rdy_m && !mv;
        if (known) begin
            check("mem_ready", out_mem_ready, rdy_m);
            check("alu_ready", out_alu_ready, rdy_a);
            check("write", out_write, m_w);
            if (m_w) begin
                check("dst_idx", out_dst_idx, m_idx);
                check("dst", out_dst, m_data);
            end
            check("pending", out_pending, ref_pending());
            check("byp1", {out_byp1_hit, out_byp1_data}, ref_byp(s1));
            check("byp2", {out_byp2_hit, out_byp2_data}, ref_byp(s2));
        end
        acc = (mv && rdy_m) || (av && rdy_a);
        e.idx  = mv ? mi : ai;
        e.data = mv ? md : ad;
        acc = acc && e.idx != 0;
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_w = 0; m_idx = 0; m_data = 0;
            known = 1;
        end else if (st) begin
            m_w = 0;
            if (acc) q.push_back(e);
        end else if (q.size() > 0) begin
            m_w = 1; m_idx = q[0].idx; m_data = q[0].data;
            void'(q.pop_front());
            if (acc) q.push_back(e);
        end else if (acc) begin
            m_w = 1; m_idx = e.idx; m_data = e.data;
        end else begin
            m_w = 0;
        end
    endtask

    task automatic idle(input bit st);
        cycle(0, 0, 0, 0, 0, 0, 0, st, 0, 0);
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        check("rst_write", out_write, 0);
        check("rst_pend", out_pending, 0);

        cycle(0, 0, 0, 0, 1, 3, 16'h1234, 0, 0, 0);
        settle();
        check("cut_write", out_write, 1);
        check("cut_idx", out_dst_idx, 3);
        check("cut_data", out_dst, 16'h1234);
        check("cut_pend", out_pending, 16'h0008);
        idle(0);
        settle();
        check("cut_pend_gone", out_pending, 0);

        cycle(0, 1, 5, 16'hAAAA, 1, 6, 16'hBBBB, 0, 0, 0);
        settle();
        check("prio_r5", out_dst_idx, 5);
        cycle(0, 0, 0, 0, 1, 6, 16'hBBBB, 0, 0, 0);
        settle();
        check("prio_r6", out_dst, 16'hBBBB);
        idle(0);

        for (int i = 1; i <= 4; i++)
            cycle(0, 1, 4'(i), 16'(i), 0, 0, 0, 1, 0, 0);
        settle();
        check("full_ready", out_mem_ready, 0);
        check("full_pend", out_pending, 16'h001E);
        idle(0);
        settle();
        check("drain_first", out_dst_idx, 1);
        for (int i = 0; i < 4; i++) idle(0);
        settle();
        check("drain_ready", out_mem_ready, 1);

        cycle(0, 0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0);
        settle();
        check("r0_write", out_write, 0);
        check("r0_pend", out_pending, 0);

        cycle(0, 0, 0, 0, 1, 7, 16'h1111, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 7, 16'h2222, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        settle();
        check("byp1_hit", out_byp1_hit, BYP);
        check("byp1_data", out_byp1_data, BYP ? 16'h2222 : 16'h0);
        check("byp2_hit", out_byp2_hit, 0);
        for (int i = 0; i < 4; i++) idle(0);

        for (int i = 8; i <= 10; i++)
            cycle(0, 1, 4'(i), 16'(i * 3), 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        check("rst2_write", out_write, 0);
        check("rst2_pend", out_pending, 0);
        check("rst2_mrdy", out_mem_ready, 1);
        check("rst2_ardy", out_alu_ready, 1);
        for (int i = 0; i < 4; i++) idle(0);

        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 2) == 0, 4'($urandom), 16'($urandom),
                  $urandom_range(0, 1) == 0, 4'($urandom), 16'($urandom),
                  $urandom_range(0, 3) == 0,
                  4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
